pkt_fifo_sync: RTL and testbench



---
 rtl/pkt_fifo_sync_pkg.sv | 21 ++
 rtl/pkt_fifo_sync_if.sv | 43 ++++
 rtl/pkt_fifo_sync_prefetch.sv | 58 +++++
 rtl/pkt_fifo_sync.sv | 179 +++++++++++++++++
 tb/tb_pkt_fifo_sync.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_fifo_sync_pkg.sv
// Shared types and constants for the packet-aware synchronous FIFO.
// Holds the write-side state encoding, the statistics counter width and
// a saturating-increment helper used by the optional statistics counters.
package pkt_fifo_pkg;

  localparam int STAT_W = 16;

  // Write-side state: IDLE = no open packet, OPEN = uncommitted words
  // present (wptr != wptr_commit), OVF = overflow seen, packet will be dropped.
  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_OPEN = 2'd1,
    WS_OVF  = 2'd2
  } wstate_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_fifo_sync_if.sv
// Bus interface of pkt_fifo_sync: packet write port, FWFT read stream,
// level/status outputs and statistics.
//
// Read handshake: rvalid says rdata/rlast hold a word; the word is
// transferred on a rising edge where rvalid && rready are both high.
// rvalid never depends on rready, and once rvalid is high, rdata/rlast
// stay unchanged until that transfer happens.
interface pkt_fifo_sync_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int W_EL       = 20
);
  import pkt_fifo_pkg::*;

  logic                  wen;
  logic [W_EL-1:0]       wdata;
  logic                  wlast;
  logic                  wabort;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  rvalid;
  logic                  rready;
  logic [W_EL-1:0]       rdata;
  logic                  rlast;
  logic [ADDR_WIDTH:0]   pkt_count;
  logic [STAT_W-1:0]     stat_commit_cnt;
  logic [STAT_W-1:0]     stat_drop_cnt;

  // Producer/consumer side (drives writes and rready).
  modport master (
    output wen, wdata, wlast, wabort, rready,
    input  full, almost_full, wlevel, rvalid, rdata, rlast, pkt_count,
           stat_commit_cnt, stat_drop_cnt
  );

  // FIFO side.
  modport slave (
    input  wen, wdata, wlast, wabort, rready,
    output full, almost_full, wlevel, rvalid, rdata, rlast, pkt_count,
           stat_commit_cnt, stat_drop_cnt
  );

endinterface

// File: rtl/pkt_fifo_sync_prefetch.sv
// fifo_prefetch: 2-entry first-word-fall-through skid buffer in front of a
// synchronous-read memory. It requests a memory read (issue) whenever the
// source has data and there is room for the word once it lands, counting
// the read still in flight. Read data is expected one cycle after issue.
module fifo_prefetch #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         avail,
  output logic         issue,
  input  logic [W-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] ent_q [2];
  logic         head;
  logic         tail;
  logic [1:0]   cnt;
  logic         inflight;
  logic         pop;
  logic         push;
  logic         space_ok;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = ent_q[head];
  assign pop       = out_valid && out_ready;
  assign push      = inflight;

  // An entry leaving this cycle makes room for a read issued this cycle.
  assign space_ok = ({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign issue    = avail && space_ok;

  // Entry storage, ring pointers, occupancy and in-flight tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (push) begin
        ent_q[tail] <= rd_data;
        tail        <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/pkt_fifo_sync.sv
// pkt_fifo_sync: packet-aware synchronous FIFO. Words of a packet become
// visible to the reader only after the word carrying wlast is accepted;
// an explicit wabort, or wlast arriving after an overflow, rewinds the
// write head to the last commit point. The read side is an FWFT stream.
// Optional statistics counters are built when PKT_FIFO_SYNC_STATS_EN is
// defined; otherwise the statistic outputs are constant zero.
module pkt_fifo_sync
  import pkt_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int W_EL       = 20,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 64
) (
  input  logic                clk,
  input  logic                reset_n,
  pkt_fifo_sync_if.slave      bus,
  output wstate_e             wstate
);

  localparam int          DEPTH    = 2**ADDR_WIDTH;
  localparam int          PW       = ADDR_WIDTH + 1;
  localparam int          MW       = W_EL + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam int unsigned AF_U     = AF_THRESH;

  logic [PW-1:0] wptr, wptr_n;
  logic [PW-1:0] wptr_commit, commit_n;
  logic [PW-1:0] rptr;
  wstate_e       wstate_n;
  logic          ovf, ovf_n;
  logic          open_pkt;
  logic          mem_we;
  logic          commit_evt;
  logic          drop_evt;
  logic          rd_issue;
  logic          last_hs;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] mem_q;
  logic [MW-1:0] pf_data;
  logic [PW-1:0] pkt_cnt;

  assign ovf        = (wstate == WS_OVF);
  assign open_pkt   = (wptr != wptr_commit);
  assign bus.wlevel = wptr - rptr;
  assign bus.full   = (bus.wlevel == FULL_LVL);
  assign bus.almost_full = (32'(bus.wlevel) >= AF_U);

  // Write-side next state: abort has priority, then accept / drop / overflow.
  always_comb begin
    wptr_n     = wptr;
    commit_n   = wptr_commit;
    ovf_n      = ovf;
    mem_we     = 1'b0;
    commit_evt = 1'b0;
    drop_evt   = 1'b0;
    if (bus.wabort) begin
      if (open_pkt || ovf) begin
        wptr_n   = wptr_commit;
        ovf_n    = 1'b0;
        drop_evt = 1'b1;
      end
    end else if (bus.wen) begin
      if (ovf) begin
        if (bus.wlast) begin
          wptr_n   = wptr_commit;
          ovf_n    = 1'b0;
          drop_evt = 1'b1;
        end
      end else if (bus.full) begin
        ovf_n = 1'b1;
      end else begin
        mem_we = 1'b1;
        wptr_n = wptr + 1'b1;
        if (bus.wlast) begin
          commit_n   = wptr + 1'b1;
          commit_evt = 1'b1;
        end
      end
    end
    if (ovf_n) begin
      wstate_n = WS_OVF;
    end else if (wptr_n != commit_n) begin
      wstate_n = WS_OPEN;
    end else begin
      wstate_n = WS_IDLE;
    end
  end

  // Write-side state machine and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= '0;
      wptr_commit <= '0;
      wstate      <= WS_IDLE;
    end else begin
      wptr        <= wptr_n;
      wptr_commit <= commit_n;
      wstate      <= wstate_n;
    end
  end

  // Storage: one write port, one synchronous read port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= {bus.wlast, bus.wdata};
    end
    if (rd_issue) begin
      mem_q <= mem[rptr[ADDR_WIDTH-1:0]];
    end
  end

  // Read pointer advances as each word is pulled into the prefetch buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr <= '0;
    end else if (rd_issue) begin
      rptr <= rptr + 1'b1;
    end
  end

  fifo_prefetch #(.W(MW)) u_prefetch (
    .clk       (clk),
    .reset_n   (reset_n),
    .avail     (rptr != wptr_commit),
    .issue     (rd_issue),
    .rd_data   (mem_q),
    .out_valid (bus.rvalid),
    .out_ready (bus.rready),
    .out_data  (pf_data)
  );

  assign bus.rlast = pf_data[W_EL];
  assign bus.rdata = pf_data[W_EL-1:0];
  assign last_hs   = bus.rvalid && bus.rready && bus.rlast;

  // Committed packets not yet fully handed to the reader.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit_evt, last_hs})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  assign bus.pkt_count = pkt_cnt;

`ifdef PKT_FIFO_SYNC_STATS_EN
  logic [STAT_W-1:0] commit_cnt;
  logic [STAT_W-1:0] drop_cnt;

  // Saturating commit/drop statistics, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (commit_evt) begin
        commit_cnt <= sat_inc(commit_cnt);
      end
      if (drop_evt) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign bus.stat_commit_cnt = commit_cnt;
  assign bus.stat_drop_cnt   = drop_cnt;
`else
  logic unused_drop;
  assign unused_drop         = drop_evt;
  assign bus.stat_commit_cnt = '0;
  assign bus.stat_drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_pkt_fifo_sync.sv
// Directed bench for pkt_fifo_sync at depth 16 with a read-side scoreboard.
`timescale 1ns/1ps
module tb_pkt_fifo_sync;
  import pkt_fifo_pkg::*;

  localparam int AW  = 4;
  localparam int W   = 20;
  localparam int AFT = 12;
`ifdef PKT_FIFO_SYNC_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wstate_e wstate;
  pkt_fifo_sync_if #(.ADDR_WIDTH(AW), .W_EL(W)) bus ();
  pkt_fifo_sync #(.ADDR_WIDTH(AW), .W_EL(W), .AF_THRESH(AFT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .wstate  (wstate)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [W:0] exp_q[$];
  logic [W:0] pend_q[$];
  int         hs_cyc_q[$];
  int         exp_commits = 0;
  int         exp_drops   = 0;
  logic [W:0] prev_data;
  logic       prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_stat(input int n);
    return 16'(n) & {16{STATS_ON}};
  endfunction

  // Monitor: compare every transferred word, and hold-stability while stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.rvalid), 64'd1);
        chk("stall_hold", 64'({bus.rlast, bus.rdata}), 64'(prev_data));
      end
      if (bus.rvalid && bus.rready) begin
        hs_cyc_q.push_back(cyc);
        chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("rdata", 64'({bus.rlast, bus.rdata}), 64'(exp_q.pop_front()));
      end
      prev_stall = bus.rvalid && !bus.rready;
      prev_data  = {bus.rlast, bus.rdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic last);
    logic [W-1:0] d;
    d = W'($urandom_range(0, (1 << W) - 1));
    bus.wen = 1'b1; bus.wdata = d; bus.wlast = last;
    pend_q.push_back({last, d});
    if (last) begin
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
      exp_commits++;
    end
    tick();
    bus.wen = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic put_pkt(input int n);
    for (int i = 0; i < n; i++) put_word(i == n - 1);
  endtask

  // Word expected to be dropped by the FIFO.
  task automatic put_lost(input logic last);
    bus.wen = 1'b1; bus.wlast = last;
    bus.wdata = W'($urandom_range(0, (1 << W) - 1));
    tick();
    bus.wen = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic do_abort();
    bus.wabort = 1'b1;
    tick();
    bus.wabort = 1'b0;
    pend_q.delete();
    exp_drops++;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rvalid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(n < budget), 64'd1);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_commit"}, 64'(bus.stat_commit_cnt), 64'(exp_stat(exp_commits)));
    chk({tag, "_drop"}, 64'(bus.stat_drop_cnt), 64'(exp_stat(exp_drops)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd0);
    chk({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
    chk({tag, "_rlast"}, 64'(bus.rlast), 64'd0);
    chk({tag, "_full"}, 64'(bus.full), 64'd0);
    chk({tag, "_afull"}, 64'(bus.almost_full), 64'd0);
    chk({tag, "_wlevel"}, 64'(bus.wlevel), 64'd0);
    chk({tag, "_pkts"}, 64'(bus.pkt_count), 64'd0);
    chk({tag, "_stat_c"}, 64'(bus.stat_commit_cnt), 64'd0);
    chk({tag, "_stat_d"}, 64'(bus.stat_drop_cnt), 64'd0);
    chk({tag, "_wstate"}, 64'(wstate), 64'(WS_IDLE));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.wen = 1'b0; bus.wdata = '0; bus.wlast = 1'b0;
    bus.wabort = 1'b0; bus.rready = 1'b0;
    #2 reset_n = 1'b0;
    #10;
    chk_reset_outputs("por");
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Latency and back-to-back read of a 3-word packet.
    bus.rready = 1'b1;
    hs_cyc_q.delete();
    put_pkt(3);
    chk("a_pkts_commit", 64'(bus.pkt_count), 64'd1);
    chk("a_wlevel", 64'(bus.wlevel), 64'd3);
    chk("a_rvalid_e0", 64'(bus.rvalid), 64'd0);
    tick();
    chk("a_rvalid_e1", 64'(bus.rvalid), 64'd0);
    tick();
    chk("a_rvalid_e2", 64'(bus.rvalid), 64'd1);
    tick(); tick(); tick();
    chk("a_pkts_done", 64'(bus.pkt_count), 64'd0);
    chk("a_rvalid_end", 64'(bus.rvalid), 64'd0);
    chk("a_words", 64'(hs_cyc_q.size()), 64'd3);
    if (hs_cyc_q.size() == 3) chk("a_span", 64'(hs_cyc_q[2] - hs_cyc_q[0]), 64'd2);

    // Explicit abort, then a 1-word packet.
    put_word(1'b0);
    put_word(1'b0);
    chk("ab_state_open", 64'(wstate), 64'(WS_OPEN));
    do_abort();
    chk("ab_state_idle", 64'(wstate), 64'(WS_IDLE));
    chk("ab_wlevel", 64'(bus.wlevel), 64'd0);
    put_pkt(1);
    wait_drain(20);
    chk_stats("ab");
    // Abort with nothing open is a no-op.
    bus.wabort = 1'b1;
    tick();
    bus.wabort = 1'b0;
    chk_stats("noop");
    // wen together with wabort is ignored, open word discarded.
    put_word(1'b0);
    bus.wabort = 1'b1; bus.wen = 1'b1; bus.wlast = 1'b1;
    tick();
    bus.wabort = 1'b0; bus.wen = 1'b0; bus.wlast = 1'b0;
    pend_q.delete();
    exp_drops++;
    chk("abw_wlevel", 64'(bus.wlevel), 64'd0);
    chk("abw_state", 64'(wstate), 64'(WS_IDLE));
    tick(); tick(); tick();
    chk("abw_rvalid", 64'(bus.rvalid), 64'd0);
    chk_stats("abw");

    // Overflow: fill to full with reader stalled, next packet is dropped.
    bus.rready = 1'b0;
    for (int p = 0; p < 3; p++) put_pkt(3);
    chk("ov_afull_low", 64'(bus.almost_full), 64'd0);
    chk("ov_wlevel_mid", 64'(bus.wlevel), 64'd7);
    for (int p = 0; p < 3; p++) put_pkt(3);
    chk("ov_full", 64'(bus.full), 64'd1);
    chk("ov_afull", 64'(bus.almost_full), 64'd1);
    chk("ov_wlevel", 64'(bus.wlevel), 64'd16);
    chk("ov_pkts", 64'(bus.pkt_count), 64'd6);
    put_lost(1'b0);
    chk("ov_state", 64'(wstate), 64'(WS_OVF));
    put_lost(1'b0);
    put_lost(1'b1);
    exp_drops++;
    chk("ov_state_after", 64'(wstate), 64'(WS_IDLE));
    chk("ov_wlevel_after", 64'(bus.wlevel), 64'd16);
    chk("ov_pkts_after", 64'(bus.pkt_count), 64'd6);
    chk_stats("ov");
    bus.rready = 1'b1;
    wait_drain(40);
    chk("ov_pkts_drained", 64'(bus.pkt_count), 64'd0);
    chk("ov_full_drained", 64'(bus.full), 64'd0);

    // Continuous 1-word packets across pointer wrap.
    hs_cyc_q.delete();
    for (int i = 0; i < 40; i++) put_pkt(1);
    wait_drain(20);
    chk("st_words", 64'(hs_cyc_q.size()), 64'd40);
    if (hs_cyc_q.size() == 40) chk("st_span", 64'(hs_cyc_q[39] - hs_cyc_q[0]), 64'd39);

    // Reader toggling ready every cycle.
    bus.rready = 1'b0;
    for (int p = 0; p < 4; p++) put_pkt(3);
    for (int i = 0; i < 80 && (exp_q.size() != 0 || bus.rvalid); i++) begin
      bus.rready = ~bus.rready;
      tick();
    end
    bus.rready = 1'b1;
    chk("tg_drained", 64'(exp_q.size()), 64'd0);
    chk("tg_pkts", 64'(bus.pkt_count), 64'd0);
    chk_stats("tg");

    // Reset in the middle of a read and an open packet.
    bus.rready = 1'b0;
    put_pkt(3);
    tick(); tick();
    chk("rs_rvalid_pre", 64'(bus.rvalid), 64'd1);
    bus.rready = 1'b1;
    put_word(1'b0);
    put_word(1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    exp_q.delete();
    pend_q.delete();
    exp_commits = 0;
    exp_drops   = 0;
    @(negedge clk) reset_n = 1'b1;
    tick();
    put_pkt(2);
    wait_drain(20);
    chk("rs_pkts", 64'(bus.pkt_count), 64'd0);
    chk_stats("rs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
